time_keeper: RTL and testbench

//  Running BCD calendar clock; consumer of the time-setting block's outputs.

---
 rtl/clk_pkg.sv | 67 ++++++
 rtl/days_in_month.sv | 18 +
 rtl/time_keeper.sv | 155 +++++++++++++++
 tb/tb_time_keeper.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// Shared constants, time bundle and BCD helpers
// for the running calendar clock.
package clk_pkg;

    localparam logic [15:0] RST_YEAR   = 16'h2023;
    localparam logic [7:0]  RST_MONTH  = 8'h01;
    localparam logic [7:0]  RST_DAY    = 8'h01;
    localparam logic [7:0]  RST_HOUR   = 8'h00;
    localparam logic [7:0]  RST_MINUTE = 8'h00;
    localparam logic [7:0]  RST_SEC    = 8'h00;

    localparam logic [7:0] MAX_SEC    = 8'h59;
    localparam logic [7:0] MAX_MINUTE = 8'h59;
    localparam logic [7:0] MAX_HOUR   = 8'h23;
    localparam logic [7:0] MAX_MONTH  = 8'h12;

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minute;
        logic [7:0]  sec;
    } bcd_time_t;

    localparam bcd_time_t RST_TIME = '{
        year:   RST_YEAR,
        month:  RST_MONTH,
        day:    RST_DAY,
        hour:   RST_HOUR,
        minute: RST_MINUTE,
        sec:    RST_SEC
    };

    function automatic logic bcd_div4(input logic [7:0] v);
        if (v[4]) begin
            return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        end
        return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) ||
               (v[3:0] == 4'd8);
    endfunction

    function automatic logic is_leap(input logic [15:0] y);
        if (y[7:0] != 8'h00) begin
            return bcd_div4(y[7:0]);
        end
        return bcd_div4(y[15:8]);
    endfunction

    // Two-digit increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [7:0] hi;
        hi = (v[7:0] == 8'h99) ? bcd_inc(v[15:8]) : v[15:8];
        return {hi, bcd_inc(v[7:0])};
    endfunction

endpackage

// File: rtl/days_in_month.sv
// Month length in BCD for a BCD month and leap flag.
// Unknown months report 31; load validation rejects them anyway.
module days_in_month (
    input  logic [7:0] month,
    input  logic       leap,
    output logic [7:0] max_day
);

    always_comb begin
        max_day = 8'h31;
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
            8'h02: max_day = leap ? 8'h29 : 8'h28;
            default: max_day = 8'h31;
        endcase
    end

endmodule

// File: rtl/time_keeper.sv
// BCD calendar clock: prescaled 1 Hz advance with
// full carry chain and validated atomic load.
module time_keeper
    import clk_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] year_in,
    input  logic [7:0]  month_in,
    input  logic [7:0]  day_in,
    input  logic [7:0]  hour_in,
    input  logic [7:0]  minute_in,
    input  logic [7:0]  sec_in,
    output logic [15:0] year,
    output logic [7:0]  month,
    output logic [7:0]  day,
    output logic [7:0]  hour,
    output logic [7:0]  minute,
    output logic [7:0]  sec,
    output logic        sec_pulse,
    output logic        load_err
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] TC = PW'(CLK_FREQ - 1);

    bcd_time_t       t_q, t_d, t_in, t_adv;
    logic [PW-1:0]   presc_q, presc_d;
    logic            pulse_q, pulse_d;
    logic            err_q, err_d;
    logic            cur_leap, in_leap;
    logic [7:0]      cur_max, in_max;
    logic            nib_ok, rng_ok, load_ok, tc;
    logic            c_sec, c_min, c_hr, c_day, c_mon;

    assign t_in = '{
        year:   year_in,
        month:  month_in,
        day:    day_in,
        hour:   hour_in,
        minute: minute_in,
        sec:    sec_in
    };

    assign cur_leap = is_leap(t_q.year);
    assign in_leap  = is_leap(year_in);

    days_in_month u_dim_cur (
        .month   (t_q.month),
        .leap    (cur_leap),
        .max_day (cur_max)
    );

    days_in_month u_dim_in (
        .month   (month_in),
        .leap    (in_leap),
        .max_day (in_max)
    );

    // Ripple carry through all fields in a single cycle.
    always_comb begin
        t_adv = t_q;
        c_sec = (t_q.sec == MAX_SEC);
        c_min = c_sec && (t_q.minute == MAX_MINUTE);
        c_hr  = c_min && (t_q.hour == MAX_HOUR);
        c_day = c_hr && (t_q.day == cur_max);
        c_mon = c_day && (t_q.month == MAX_MONTH);
        t_adv.sec = c_sec ? 8'h00 : bcd_inc(t_q.sec);
        if (c_sec) begin
            t_adv.minute = (t_q.minute == MAX_MINUTE) ?
                           8'h00 : bcd_inc(t_q.minute);
        end
        if (c_min) begin
            t_adv.hour = (t_q.hour == MAX_HOUR) ?
                         8'h00 : bcd_inc(t_q.hour);
        end
        if (c_hr) begin
            t_adv.day = (t_q.day == cur_max) ?
                        8'h01 : bcd_inc(t_q.day);
        end
        if (c_day) begin
            t_adv.month = (t_q.month == MAX_MONTH) ?
                          8'h01 : bcd_inc(t_q.month);
        end
        if (c_mon) begin
            t_adv.year = bcd_inc16(t_q.year);
        end
    end

    // Range compares on raw bits are safe once every nibble is a digit.
    always_comb begin
        nib_ok = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (t_in[4*i +: 4] > 4'd9) begin
                nib_ok = 1'b0;
            end
        end
        rng_ok = (month_in >= 8'h01) && (month_in <= MAX_MONTH) &&
                 (day_in >= 8'h01) && (day_in <= in_max) &&
                 (hour_in <= MAX_HOUR) &&
                 (minute_in <= MAX_MINUTE) &&
                 (sec_in <= MAX_SEC);
        load_ok = nib_ok && rng_ok;
    end

    assign tc = run && (presc_q == TC);

    always_comb begin
        t_d     = t_q;
        presc_d = presc_q;
        pulse_d = 1'b0;
        err_d   = 1'b0;
        if (load && load_ok) begin
            t_d     = t_in;
            presc_d = '0;
        end else begin
            err_d = load;
            if (run) begin
                presc_d = tc ? '0 : presc_q + PW'(1);
                pulse_d = tc;
                if (tc) begin
                    t_d = t_adv;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q     <= RST_TIME;
            presc_q <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            t_q     <= t_d;
            presc_q <= presc_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign year      = t_q.year;
    assign month     = t_q.month;
    assign day       = t_q.day;
    assign hour      = t_q.hour;
    assign minute    = t_q.minute;
    assign sec       = t_q.sec;
    assign sec_pulse = pulse_q;
    assign load_err  = err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Random + directed bench for time_keeper against
// an integer calendar model.
module tb_time_keeper;

    localparam int F = 4;

    logic        clk = 1'b0;
    logic        rst_n, run, load;
    logic [15:0] year_in;
    logic [7:0]  month_in, day_in, hour_in, minute_in, sec_in;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minute, sec;
    logic        sec_pulse, load_err;

    int n_cmp = 0;
    int n_err = 0;

    int m_y, m_mo, m_d, m_h, m_mi, m_s, m_p;
    bit m_pulse, m_err;

    always #5 clk = ~clk;

    time_keeper #(.CLK_FREQ(F)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .load      (load),
        .year_in   (year_in),
        .month_in  (month_in),
        .day_in    (day_in),
        .hour_in   (hour_in),
        .minute_in (minute_in),
        .sec_in    (sec_in),
        .year      (year),
        .month     (month),
        .day       (day),
        .hour      (hour),
        .minute    (minute),
        .sec       (sec),
        .sec_pulse (sec_pulse),
        .load_err  (load_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] b8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] b16(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Decimal value of a BCD field, -1 when any nibble is not a digit.
    function automatic int dec(input logic [15:0] b);
        int v = 0;
        for (int i = 3; i >= 0; i--) begin
            if (b[4*i +: 4] > 4'd9) return -1;
            v = v * 10 + int'(b[4*i +: 4]);
        end
        return v;
    endfunction

    function automatic bit leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim(input int mo, input int y);
        case (mo)
            4, 6, 9, 11: return 30;
            2: return leap(y) ? 29 : 28;
            default: return 31;
        endcase
    endfunction

    function automatic logic [63:0] obs();
        return {6'b0, year, month, day, hour, minute, sec,
                sec_pulse, load_err};
    endfunction

    function automatic logic [63:0] expv();
        return {6'b0, b16(m_y), b8(m_mo), b8(m_d), b8(m_h),
                b8(m_mi), b8(m_s), m_pulse, m_err};
    endfunction

    task automatic model_step();
        int y, mo, d, h, mi, s;
        bit ok;
        m_pulse = 0;
        m_err   = 0;
        if (!rst_n) begin
            m_y = 2023; m_mo = 1; m_d = 1;
            m_h = 0; m_mi = 0; m_s = 0; m_p = 0;
            return;
        end
        y  = dec(year_in);
        mo = dec({8'h00, month_in});
        d  = dec({8'h00, day_in});
        h  = dec({8'h00, hour_in});
        mi = dec({8'h00, minute_in});
        s  = dec({8'h00, sec_in});
        ok = (y >= 0) && (mo >= 1) && (mo <= 12) && (d >= 1) &&
             (h >= 0) && (h < 24) && (mi >= 0) && (mi < 60) &&
             (s >= 0) && (s < 60);
        if (ok) ok = (d <= dim(mo, y));
        if (load && ok) begin
            m_y = y; m_mo = mo; m_d = d;
            m_h = h; m_mi = mi; m_s = s; m_p = 0;
            return;
        end
        m_err = load;
        if (!run) return;
        if (m_p != F - 1) begin
            m_p++;
            return;
        end
        m_p = 0;
        m_pulse = 1;
        if (++m_s < 60) return;
        m_s = 0;
        if (++m_mi < 60) return;
        m_mi = 0;
        if (++m_h < 24) return;
        m_h = 0;
        if (++m_d <= dim(m_mo, m_y)) return;
        m_d = 1;
        if (++m_mo <= 12) return;
        m_mo = 1;
        m_y = (m_y + 1) % 10000;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("cycle", obs(), expv());
    endtask

    task automatic drive_raw(input logic [15:0] y, input logic [7:0] mo,
                             input logic [7:0] d, input logic [7:0] h,
                             input logic [7:0] mi, input logic [7:0] s);
        year_in = y; month_in = mo; day_in = d;
        hour_in = h; minute_in = mi; sec_in = s;
    endtask

    task automatic load_raw(input logic [15:0] y, input logic [7:0] mo,
                            input logic [7:0] d, input logic [7:0] h,
                            input logic [7:0] mi, input logic [7:0] s);
        drive_raw(y, mo, d, h, mi, s);
        load = 1'b1;
        cyc();
        load = 1'b0;
    endtask

    task automatic load_dt(input int y, input int mo, input int d,
                           input int h, input int mi, input int s);
        load_raw(b16(y), b8(mo), b8(d), b8(h), b8(mi), b8(s));
    endtask

    function automatic logic [55:0] now();
        return {year, month, day, hour, minute, sec};
    endfunction

    // Runs one prescaler period and checks exactly one pulse appeared.
    task automatic tick(input string tag);
        int np = 0;
        for (int i = 0; i < F; i++) begin
            cyc();
            if (sec_pulse) np++;
        end
        chk(tag, 64'(np), 64'd1);
    endtask

    task automatic rand_load();
        int y, mo, d, h, mi, s, k;
        k = $urandom_range(0, 5);
        y = $urandom_range(0, 9999);
        if (k == 0) begin
            case ($urandom_range(0, 5))
                0: y = 0;
                1: y = 1900;
                2: y = 2000;
                3: y = 2100;
                4: y = 2024;
                default: y = 9999;
            endcase
        end
        mo = $urandom_range(1, 12);
        d  = $urandom_range(1, dim(mo, y));
        h  = $urandom_range(0, 23);
        mi = $urandom_range(0, 59);
        s  = $urandom_range(0, 59);
        if (k <= 2) begin
            d = dim(mo, y); h = 23; mi = 59;
            s = $urandom_range(56, 59);
        end
        if (k == 5) begin
            load_raw(16'($urandom), 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom));
        end else if (k == 4) begin
            load_dt(y, mo, dim(mo, y) + 1, h, mi, s);
        end else begin
            load_dt(y, mo, d, h, mi, s);
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; load = 1'b0;
        drive_raw(16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        cyc();
        cyc();
        chk("reset", {8'h0, now()}, {8'h0, 56'h2023_01_01_000000});

        rst_n = 1'b1; run = 1'b1;
        for (int i = 0; i < 3 * F; i++) cyc();
        chk("sec3", {56'h0, sec}, 64'h03);

        load_dt(2023, 12, 31, 23, 59, 59);
        tick("nye_pulse");
        chk("nye", {8'h0, now()}, {8'h0, 56'h2024_01_01_000000});

        load_dt(2024, 2, 28, 23, 59, 59);
        tick("l2024_pulse");
        chk("leap2024", {8'h0, now()}, {8'h0, 56'h2024_02_29_000000});
        load_dt(2100, 2, 28, 23, 59, 59);
        tick("l2100_pulse");
        chk("noleap2100", {8'h0, now()}, {8'h0, 56'h2100_03_01_000000});
        load_dt(2000, 2, 28, 23, 59, 59);
        tick("l2000_pulse");
        chk("leap2000", {8'h0, now()}, {8'h0, 56'h2000_02_29_000000});

        load_raw(16'h2023, 8'h02, 8'h29, 8'h10, 8'h00, 8'h00);
        chk("err_feb29", {63'h0, load_err}, 64'd1);
        load_raw(16'h2023, 8'h13, 8'h01, 8'h10, 8'h00, 8'h00);
        chk("err_mon13", {63'h0, load_err}, 64'd1);
        load_raw(16'h2023, 8'h05, 8'h01, 8'h10, 8'h5A, 8'h00);
        chk("err_min5a", {63'h0, load_err}, 64'd1);
        for (int i = 0; i < F; i++) cyc();
        chk("err_ticks", {8'h0, now()}, {8'h0, 56'h2000_02_29_000001});

        for (int i = 0; i < 2 * F && m_p != F - 1; i++) cyc();
        load_dt(2022, 6, 15, 10, 20, 30);
        chk("tc_load", {7'h0, now(), sec_pulse},
            {7'h0, 56'h2022_06_15_102030, 1'b0});
        run = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("frozen", {8'h0, now()}, {8'h0, 56'h2022_06_15_102030});
        run = 1'b1;
        tick("restart_pulse");
        chk("restart", {8'h0, now()}, {8'h0, 56'h2022_06_15_102031});

        load_dt(9999, 12, 31, 23, 59, 59);
        tick("y10k_pulse");
        chk("y10k", {8'h0, now()}, {8'h0, 56'h0000_01_01_000000});

        cyc();
        cyc();
        rst_n = 1'b0;
        drive_raw(16'h1999, 8'h07, 8'h04, 8'h12, 8'h34, 8'h56);
        load = 1'b1;
        cyc();
        chk("rst_wins", {6'h0, now(), sec_pulse, load_err},
            {6'h0, 56'h2023_01_01_000000, 2'b00});
        rst_n = 1'b1; load = 1'b0;
        cyc();
        chk("post_rst", {62'h0, sec_pulse, load_err}, 64'd0);

        for (int i = 0; i < 3000; i++) begin
            run   = ($urandom_range(0, 7) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 15) == 0) begin
                rand_load();
            end else begin
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
